// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - b_in one bit per clock, LSB first,
// and reports the difference and borrow-out with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; d and b_out hold the last completed result
// BUSY  | processing one operand bit per edge, WIDTH edges in total
// DONE  | result valid, done=1 for exactly one cycle
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic            br;
  logic [CW-1:0]   cnt;
  logic            diff_bit;
  logic            br_next;

  // Full-subtractor cell fed only from registers, so outputs never see inputs combinationally
  always_comb begin
    diff_bit = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      b_out <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Difference bits enter at the MSB and reach their final position after WIDTH shifts
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          d    <= {diff_bit, d[WIDTH-1:1]};
          if (cnt == LAST) begin
            b_out <= br_next;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): latency, result values,
// input isolation, back-to-back starts, mid-operation reset and an exhaustive sweep.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       b_in = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       b_out;

  int total = 0;
  int bad = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .b_out (b_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One full operation; after the accepting edge the inputs are disturbed
  // (zeroed when clobber=1, inverted otherwise) to prove they were latched.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic clobber, input logic [3:0] ed, input logic eb,
                        input string tag);
    @(negedge clk);
    a = ta; b = tb_v; b_in = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (clobber) begin
      a = 4'h0; b = 4'h0; b_in = 1'b0;
    end else begin
      a = ~ta; b = ~tb_v; b_in = ~tbin;
    end
    chk({tag, " busy_after_accept"}, busy, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        chk({tag, " done_early"}, done, 1'b0);
      end else begin
        chk({tag, " done_pulse"}, done, 1'b1);
        chk({tag, " d"}, d, ed);
        chk({tag, " b_out"}, b_out, eb);
      end
    end
    @(posedge clk); #1;
    chk({tag, " done_clears"}, done, 1'b0);
    chk({tag, " busy_clears"}, busy, 1'b0);
    chk({tag, " d_holds"}, d, ed);
  endtask

  initial begin
    int n;
    logic [4:0] e;

    // Reset state
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst d", d, 4'h0);
    chk("rst b_out", b_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: first start after reset, latency WIDTH
    run_op(4'd9, 4'd3, 1'b0, 1'b0, 4'd6, 1'b0, "c1");

    // Idle hold: result stays put with start low
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", busy, 1'b0);
    chk("idle d_hold", d, 4'd6);
    chk("idle b_out_hold", b_out, 1'b0);

    // Case 2: borrow and boundary patterns
    run_op(4'd3, 4'd9, 1'b0, 1'b0, 4'hA, 1'b1, "c2a");
    run_op(4'd0, 4'd0, 1'b1, 1'b0, 4'hF, 1'b1, "c2b");
    run_op(4'd15, 4'd15, 1'b0, 1'b0, 4'h0, 1'b0, "c2c");

    // Case 3: start held high, one op per 6 cycles
    @(negedge clk);
    a = 4'd5; b = 4'd2; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 20);
      chk("c3 period", n, (p == 0) ? 4 : 6);
      chk("c3 d", d, 4'd3);
      chk("c3 b_out", b_out, 1'b0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("c3 idle_after", busy, 1'b0);

    // Case 4: inputs zeroed the cycle after acceptance
    run_op(4'd12, 4'd4, 1'b0, 1'b1, 4'd8, 1'b0, "c4");

    // Case 5: reset on the second BUSY edge
    @(negedge clk);
    a = 4'd14; b = 4'd1; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("c5 busy", busy, 1'b0);
    chk("c5 done", done, 1'b0);
    chk("c5 d", d, 4'h0);
    chk("c5 b_out", b_out, 1'b0);
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("c5 no_done", n, 0);
    run_op(4'd7, 4'd1, 1'b0, 1'b0, 4'd6, 1'b0, "c5new");

    // Case 6: exhaustive sweep against arithmetic model
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          e = 5'(ia) - 5'(ib) - 5'(ic);
          run_op(4'(ia), 4'(ib), 1'(ic), 1'b0, e[3:0], e[4], "c6");
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, 4, operand and result width in bits; the module SHALL support any WIDTH >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 Port: b  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 Port: b_in  input  1  borrow-in; captured on the accepting edge.
REQ-008 Port: busy  output  1  high while in BUSY or DONE.
REQ-009 Port: done  output  1  one-cycle pulse; d and b_out are valid while high.
REQ-010 Port: d  output  WIDTH  difference a - b - b_in, modulo 2^WIDTH.
REQ-011 Port: b_out  output  1  borrow-out: 1 when a < b + b_in, treating all operands as unsigned.

Function
REQ-012 The state machine SHALL have states IDLE, BUSY and DONE, all registered.
REQ-013 IDLE with start=1: on the edge, latch a, b and b_in; clear the bit counter; go to BUSY. IDLE with start=0: stay in IDLE.
REQ-014 Each BUSY edge SHALL process exactly one bit i, LSB first: d[i] = a[i]^b[i]^br; br_next = (~a[i]&b[i]) | (~(a[i]^b[i])&br). The initial br is the latched b_in.
REQ-015 BUSY SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL move the state to DONE and load the final borrow into b_out.
REQ-016 The DONE state SHALL be held for one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-018 Throughput: the next start SHALL be accepted no earlier than edge k+WIDTH+2, which gives one operation per WIDTH+2 cycles.
REQ-019 start in BUSY or DONE SHALL be ignored; no queueing and no change to the operation in progress.
REQ-020 Changes on a, b or b_in after the accepting edge SHALL have no effect on the result.
REQ-021 d and b_out SHALL hold their last completed values through IDLE until the next operation completes.
REQ-022 d and b_out MAY change during BUSY and SHALL be used only while done=1.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap inside an operation.
REQ-024 The implementation SHALL contain no combinational path from inputs to outputs.

Reset
REQ-025 rst_n=0 SHALL force, asynchronously: state=IDLE, busy=0, done=0, d=0, b_out=0, counter=0, borrow register=0.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL start a new operation.

Verification (WIDTH=4)
REQ-028 Case 1: a=9, b=3, b_in=0, start accepted at edge k -> done high after edge k+4; d=6, b_out=0.
REQ-029 Case 2: a=3, b=9, b_in=0 -> d=0xA, b_out=1; a=0, b=0, b_in=1 -> d=0xF, b_out=1; a=15, b=15, b_in=0 -> d=0, b_out=0.
REQ-030 Case 3: start held high continuously with a=5, b=2 -> done pulses every 6 cycles, each with d=3, b_out=0; start is ignored in BUSY and DONE.
REQ-031 Case 4: a and b change to 0 on the cycle after acceptance of a=12, b=4 -> result is d=8, b_out=0.
REQ-032 Case 5: rst_n pulsed low on the second BUSY edge -> outputs go to 0 immediately; no done pulse; a new op a=7, b=1 then gives d=6.
REQ-033 Case 6: exhaustive test of all 512 (a, b, b_in) combinations -> every {b_out, d} matches a - b - b_in mod 32 in two's-complement form.
